// File: rtl/wallace_mul_pkg.sv
// Shared constants and elaboration helpers for the pipelined
// Wallace multiplier (optional accumulator: MUL_ACC_EN).
package wallace_mul_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_STAGES    = 3;
  localparam int DEF_ACC_GUARD = 8;
  localparam int MAX_WIDTH     = 32;

  typedef logic [5:0] col_cnt_t [2*MAX_WIDTH];

  // Tallest Baugh-Wooley column, including the two constant ones
  function automatic int max_height(input int w);
    col_cnt_t h;
    int       m;
    m = 0;
    for (int c = 0; c < 2*MAX_WIDTH; c++) begin
      h[c] = '0;
      for (int j = 0; j < w; j++)
        if (c - j >= 0 && c - j < w) h[c] = h[c] + 6'd1;
      if (c == w || c == 2*w - 1) h[c] = h[c] + 6'd1;
      if (int'(h[c]) > m) m = int'(h[c]);
    end
    return m;
  endfunction

  function automatic int reduce_rows(input int n);
    return (n <= 2) ? n : 2*(n/3) + n%3;
  endfunction

  function automatic int rows_after(input int w, input int k);
    int n;
    n = w;
    for (int i = 0; i < k; i++) n = reduce_rows(n);
    return n;
  endfunction

  function automatic int num_levels(input int w);
    int n;
    int l;
    n = max_height(w);
    l = 0;
    while (n > 2) begin
      n = reduce_rows(n);
      l++;
    end
    return l;
  endfunction

  // Reduction levels completed by the end of segment s
  function automatic int lvl_end(input int s, input int lvls,
                                 input int stages);
    if (stages > lvls) return (s + 1 < lvls) ? s + 1 : lvls;
    return ((s + 1) * lvls) / stages;
  endfunction

  function automatic int cpa_seg(input int lvls, input int stages);
    return ((stages < lvls) ? stages : lvls) - 1;
  endfunction

endpackage

// File: rtl/wallace_csa_row.sv
// One 3:2 carry-save reduction level applied across all columns.
module wallace_csa_row #(
  parameter int W = 16
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] s,
  output logic [W-1:0] c
);

  always_comb begin
    s = x ^ y ^ z;
    c = '0;
    for (int i = 1; i < W; i++)
      c[i] = (x[i-1] & y[i-1]) | (x[i-1] & z[i-1]) |
             (y[i-1] & z[i-1]);
  end

endmodule

// File: rtl/wallace_mul_pipe.sv
// Pipelined signed/unsigned Wallace multiplier with global stall.
// Define MUL_ACC_EN to add the dot-product accumulator.
module wallace_mul_pipe
  import wallace_mul_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int STAGES    = DEF_STAGES,
  parameter int ACC_GUARD = DEF_ACC_GUARD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result
`ifdef MUL_ACC_EN
  ,
  input  logic               in_last,
  output logic               acc_valid,
  output logic [2*WIDTH+ACC_GUARD-1:0] acc_result
`endif
);

  localparam int W2      = 2 * WIDTH;
  localparam int LVLS    = num_levels(WIDTH);
  localparam int CPA_SEG = cpa_seg(LVLS, STAGES);

  typedef logic [WIDTH-1:0][W2-1:0] rows_t;

  rows_t             pp;
  rows_t             seg_out [STAGES];
  rows_t             stg_q   [STAGES];
  rows_t             stg_d   [STAGES];
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_d;
  logic              advance;
  logic              unused_rows;

  assign out_valid   = vld_q[STAGES-1];
  assign advance     = out_ready | ~out_valid;
  assign in_ready    = advance;
  assign result      = stg_q[STAGES-1][0];
  assign unused_rows = ^stg_q[STAGES-1][WIDTH-1:1];

  // Baugh-Wooley: one array serves both signed and unsigned
  always_comb begin
    pp = '0;
    for (int j = 0; j < WIDTH; j++)
      for (int i = 0; i < WIDTH; i++)
        pp[j][i+j] = (a[i] & b[j]) ^
          (is_signed & ((i == WIDTH-1) != (j == WIDTH-1)));
    pp[0][WIDTH]      = is_signed;
    pp[WIDTH-1][W2-1] = is_signed;
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_seg
    localparam int LB =
      (s == 0) ? 0 : lvl_end(s - 1, LVLS, STAGES);
    localparam int LE = lvl_end(s, LVLS, STAGES);

    rows_t seg_in;
    rows_t seg_mid;

    if (s == 0) begin : g_in_pp
      assign seg_in = pp;
    end else begin : g_in_reg
      assign seg_in = stg_q[s-1];
    end

    for (genvar k = LB + 1; k <= LE; k++) begin : g_lvl
      localparam int NI = rows_after(WIDTH, k - 1);
      localparam int NG = NI / 3;
      localparam int NR = NI - 3 * NG;
      localparam int NO = rows_after(WIDTH, k);

      rows_t li;
      rows_t lo;

      if (k == LB + 1) begin : g_first
        assign li = seg_in;
      end else begin : g_chain
        assign li = g_lvl[k-1].lo;
      end

      for (genvar t = 0; t < NG; t++) begin : g_csa
        wallace_csa_row #(.W(W2)) u_row (
          .x(li[3*t]),
          .y(li[3*t+1]),
          .z(li[3*t+2]),
          .s(lo[2*t]),
          .c(lo[2*t+1])
        );
      end

      for (genvar r = 0; r < NR; r++) begin : g_pass
        assign lo[2*NG+r] = li[3*NG+r];
      end

      for (genvar r = NO; r < WIDTH; r++) begin : g_zero
        assign lo[r] = '0;
      end

      if (NI < WIDTH) begin : g_idle
        logic unused_li;
        assign unused_li = ^li[WIDTH-1:NI];
      end
    end

    if (LE > LB) begin : g_mid
      assign seg_mid = g_lvl[LE].lo;
    end else begin : g_bypass
      assign seg_mid = seg_in;
    end

    // Product lands in row 0; later stages just carry it
    if (s == CPA_SEG) begin : g_cpa
      logic [W2-1:0] sum;
      logic          unused_cpa;
      assign sum        = seg_mid[0] + seg_mid[1];
      assign unused_cpa = ^seg_mid[WIDTH-1:2];
      assign seg_out[s] = {{((WIDTH-1)*W2){1'b0}}, sum};
    end else begin : g_thru
      assign seg_out[s] = seg_mid;
    end
  end

  always_comb begin
    vld_d = vld_q;
    stg_d = stg_q;
    if (advance) begin
      vld_d[0] = in_valid;
      for (int s = 1; s < STAGES; s++) vld_d[s] = vld_q[s-1];
      for (int s = 0; s < STAGES; s++) stg_d[s] = seg_out[s];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      stg_q <= '{default: '0};
    end else begin
      vld_q <= vld_d;
      stg_q <= stg_d;
    end
  end

`ifdef MUL_ACC_EN
  localparam int AW = W2 + ACC_GUARD;

  logic [STAGES-1:0] sgn_q;
  logic [STAGES-1:0] sgn_d;
  logic [STAGES-1:0] last_q;
  logic [STAGES-1:0] last_d;
  logic [AW-1:0]     acc_q;
  logic [AW-1:0]     acc_d;
  logic [AW-1:0]     accr_q;
  logic [AW-1:0]     accr_d;
  logic [AW-1:0]     prod_ext;
  logic [AW-1:0]     acc_sum;
  logic              accv_q;
  logic              accv_d;
  logic              out_hs;

  assign out_hs     = out_valid & out_ready;
  assign prod_ext   =
    {{ACC_GUARD{sgn_q[STAGES-1] & result[W2-1]}}, result};
  assign acc_sum    = acc_q + prod_ext;
  assign acc_valid  = accv_q;
  assign acc_result = accr_q;

  always_comb begin
    sgn_d  = sgn_q;
    last_d = last_q;
    acc_d  = acc_q;
    accr_d = accr_q;
    accv_d = 1'b0;
    if (advance) begin
      sgn_d[0]  = is_signed;
      last_d[0] = in_last;
      for (int s = 1; s < STAGES; s++) begin
        sgn_d[s]  = sgn_q[s-1];
        last_d[s] = last_q[s-1];
      end
    end
    if (out_hs) begin
      if (last_q[STAGES-1]) begin
        acc_d  = '0;
        accr_d = acc_sum;
        accv_d = 1'b1;
      end else begin
        acc_d = acc_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sgn_q  <= '0;
      last_q <= '0;
      acc_q  <= '0;
      accr_q <= '0;
      accv_q <= 1'b0;
    end else begin
      sgn_q  <= sgn_d;
      last_q <= last_d;
      acc_q  <= acc_d;
      accr_q <= accr_d;
      accv_q <= accv_d;
    end
  end
`else
  localparam int unused_acc_guard = ACC_GUARD;
`endif

endmodule

// File: tb/tb_wallace_mul_pipe.sv
// Directed and randomised checks of wallace_mul_pipe
// (W8/S3 main, W4/S1 and W16/S6 side instances).
module tb_wallace_mul_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        iv8, ir8, s8, ov8, ordy8;
  logic [7:0]  a8, b8;
  logic [15:0] res8;
  logic        iv4, ir4, s4, ov4, ordy4;
  logic [3:0]  a4, b4;
  logic [7:0]  res4;
  logic        iv16, ir16, s16, ov16, ordy16;
  logic [15:0] a16, b16;
  logic [31:0] res16;
`ifdef MUL_ACC_EN
  logic        last8, accv8, accv4, accv16;
  logic [23:0] accr8;
  logic [15:0] accr4;
  logic [39:0] accr16;
`endif

  wallace_mul_pipe #(.WIDTH(8), .STAGES(3)) u8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .is_signed(s8),
    .out_valid(ov8), .out_ready(ordy8),
    .result(res8)
`ifdef MUL_ACC_EN
    , .in_last(last8), .acc_valid(accv8), .acc_result(accr8)
`endif
  );

  wallace_mul_pipe #(.WIDTH(4), .STAGES(1)) u4 (
    .clk(clk), .rst(rst),
    .in_valid(iv4), .in_ready(ir4),
    .a(a4), .b(b4), .is_signed(s4),
    .out_valid(ov4), .out_ready(ordy4),
    .result(res4)
`ifdef MUL_ACC_EN
    , .in_last(1'b0), .acc_valid(accv4), .acc_result(accr4)
`endif
  );

  wallace_mul_pipe #(.WIDTH(16), .STAGES(6)) u16 (
    .clk(clk), .rst(rst),
    .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16), .is_signed(s16),
    .out_valid(ov16), .out_ready(ordy16),
    .result(res16)
`ifdef MUL_ACC_EN
    , .in_last(1'b0), .acc_valid(accv16), .acc_result(accr16)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] x,
    input logic [31:0] y, input logic sg, input int w);
    longint sx, sy;
    sx = longint'(x);
    sy = longint'(y);
    if (sg && x[w-1]) sx = sx - (longint'(1) << w);
    if (sg && y[w-1]) sy = sy - (longint'(1) << w);
    return 64'(sx * sy) & ((64'd1 << (2*w)) - 64'd1);
  endfunction

  logic [15:0] exp2 [4] = '{16'h4000, 16'hFFFF, 16'h00FF, 16'hC080};
  logic [7:0]  sa2  [4] = '{8'h80, 8'hFF, 8'hFF, 8'h7F};
  logic [7:0]  sb2  [4] = '{8'h80, 8'h01, 8'h01, 8'h80};
  logic        ss2  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  logic [63:0] q8[$], q4[$], q16[$];
  int          k, got;
  logic        fire_in, fire_out, drain;
`ifdef MUL_ACC_EN
  logic [23:0] acc_exp [2] = '{24'd480, 24'd9};
  logic [7:0]  ta [4] = '{8'd10, 8'd20, 8'hFB, 8'd3};
  logic [7:0]  tb [4] = '{8'd10, 8'd20, 8'd4, 8'd3};
  logic        tl [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  int          npulse;
`endif

  initial begin
    rst = 1'b1;
    iv8 = 0; a8 = 0; b8 = 0; s8 = 0; ordy8 = 1;
    iv4 = 0; a4 = 0; b4 = 0; s4 = 0; ordy4 = 1;
    iv16 = 0; a16 = 0; b16 = 0; s16 = 0; ordy16 = 1;
`ifdef MUL_ACC_EN
    last8 = 0;
`endif
    step();
    step();
    rst = 1'b0;
    step();

    // reset state; in_ready is 1 even with out_ready low
    chk("rst_out_valid", ov8, 0);
    chk("rst_result", res8, 0);
    ordy8 = 0;
    #1;
    chk("rst_in_ready", ir8, 1);
    ordy8 = 1;

    // unsigned max x max, latency of exactly STAGES
    iv8 = 1; a8 = 8'hFF; b8 = 8'hFF; s8 = 0;
    step();
    iv8 = 0;
    chk("lat_edge1", ov8, 0);
    step();
    chk("lat_edge2", ov8, 0);
    step();
    chk("lat_edge3", ov8, 1);
    chk("umax", res8, 16'hFE01);
    step();
    chk("lat_drained", ov8, 0);

    // signed/unsigned mixes streamed back to back
    for (int i = 0; i < 8; i++) begin
      iv8 = (i < 4);
      if (i < 4) begin
        a8 = sa2[i]; b8 = sb2[i]; s8 = ss2[i];
      end
      step();
      if (i >= 2 && i < 6) begin
        chk("stream_valid", ov8, 1);
        chk("stream_result", res8, exp2[i-2]);
      end
    end
    iv8 = 0;

    // backpressure: fill while output is blocked
    ordy8 = 0;
    for (int c = 0; c < 3; c++) begin
      iv8 = 1; a8 = 8'(c + 1); b8 = 3; s8 = 0;
      step();
    end
    chk("bp_in_ready_low", ir8, 0);
    chk("bp_out_valid", ov8, 1);
    chk("bp_head", res8, 3);
    iv8 = 1; a8 = 4;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_stable", res8, 3);
      chk("bp_hold_ready", ir8, 0);
    end
    k = 4;
    got = 0;
    ordy8 = 1;
    for (int c = 0; c < 12; c++) begin
      #1;
      fire_in = iv8 & ir8;
      fire_out = ov8 & ordy8;
      if (fire_out) begin
        chk("bp_order", res8, 64'(3 * (got + 1)));
        got++;
      end
      step();
      if (fire_in) begin
        k++;
        iv8 = (k <= 5);
        a8 = 8'(k);
      end
    end
    chk("bp_count", got, 5);
    chk("bp_empty", ov8, 0);

    // reset with two items in flight
    iv8 = 1; a8 = 5; b8 = 5; s8 = 0;
    step();
    a8 = 6; b8 = 6;
    step();
    iv8 = 0;
    rst = 1;
    step();
    rst = 0;
    chk("mid_rst_valid", ov8, 0);
    chk("mid_rst_result", res8, 0);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("mid_rst_flushed", ov8, 0);
    end

`ifdef MUL_ACC_EN
    // dot products: 100+400-20 = 480, then 9
    npulse = 0;
    for (int i = 0; i < 4; i++) begin
      iv8 = 1; s8 = 1; a8 = ta[i]; b8 = tb[i]; last8 = tl[i];
      step();
    end
    iv8 = 0;
    last8 = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (accv8) begin
        if (npulse < 2) chk("acc_result", accr8, acc_exp[npulse]);
        npulse++;
      end
    end
    chk("acc_pulses", npulse, 2);
`endif

    // random cross-check, random out_ready, then drain
    for (int cyc = 0; cyc < 400; cyc++) begin
      drain = (cyc >= 360);
      iv8 = !drain && ($urandom_range(0, 3) != 0);
      a8 = 8'($urandom); b8 = 8'($urandom);
      s8 = 1'($urandom_range(0, 1));
      ordy8 = drain || ($urandom_range(0, 3) != 0);
      iv4 = !drain && ($urandom_range(0, 3) != 0);
      a4 = 4'($urandom); b4 = 4'($urandom);
      s4 = 1'($urandom_range(0, 1));
      ordy4 = drain || ($urandom_range(0, 3) != 0);
      iv16 = !drain && ($urandom_range(0, 3) != 0);
      a16 = 16'($urandom); b16 = 16'($urandom);
      s16 = 1'($urandom_range(0, 1));
      ordy16 = drain || ($urandom_range(0, 3) != 0);
      #1;
      if (iv8 && ir8) q8.push_back(ref_mul(32'(a8), 32'(b8), s8, 8));
      if (iv4 && ir4) q4.push_back(ref_mul(32'(a4), 32'(b4), s4, 4));
      if (iv16 && ir16)
        q16.push_back(ref_mul(32'(a16), 32'(b16), s16, 16));
      if (ov8 && ordy8) begin
        if (q8.size() == 0) chk("rnd8_spurious", ov8, 0);
        else chk("rnd8", res8, q8.pop_front());
      end
      if (ov4 && ordy4) begin
        if (q4.size() == 0) chk("rnd4_spurious", ov4, 0);
        else chk("rnd4", res4, q4.pop_front());
      end
      if (ov16 && ordy16) begin
        if (q16.size() == 0) chk("rnd16_spurious", ov16, 0);
        else chk("rnd16", res16, q16.pop_front());
      end
      step();
    end
    chk("rnd8_left", q8.size(), 0);
    chk("rnd4_left", q4.size(), 0);
    chk("rnd16_left", q16.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
